// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle instruction sequencer in front of the register file.
// Takes 16-bit instructions over valid/ready, steps each one through
// DECODE/EXEC/MEM/WB, and drives register selects, the write strobe and the
// data memory handshake. Every port comes straight from a flop, so REG_WR
// (which gates the register file clock) cannot glitch.
module ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255     // max MEM cycles without ACK, 1..255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    input  logic        MEM_ACK,
    output logic [3:0]  Rx,
    output logic [3:0]  Ry,
    output logic [3:0]  Rz,
    output logic        REG_WR,
    output logic [2:0]  ALU_OP,
    output logic [1:0]  WB_SEL,
    output logic [15:0] IMM,
    output logic        BUSY,
    output logic        HALTED,
    output logic        ILLEGAL,
    output logic        MEM_ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_RX  = 2'b11;

    // tmo_cnt holds the number of MEM cycles already completed, so the
    // MEM_TIMEOUT-th cycle is the one where it equals MEM_TIMEOUT-1.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [3:0]  ir_op;        // only the opcode is needed after DECODE entry
    logic [7:0]  tmo_cnt;
    logic        accept;
    logic        ill_nx;
    logic        err_nx;
    logic [1:0]  wb_sel_dec;

    // INSTR_READY is high exactly while in FETCH, so this is the handshake.
    assign accept = INSTR_VALID && INSTR_READY;

    // Writeback source decoded from the incoming opcode, loaded on accept.
    always_comb begin
        wb_sel_dec = WB_ALU;
        case (INSTR[15:12])
            OP_LDI:  wb_sel_dec = WB_IMM;
            OP_LD:   wb_sel_dec = WB_MEM;
            OP_MOV:  wb_sel_dec = WB_RX;
            default: wb_sel_dec = WB_ALU;
        endcase
    end

    // Next-state logic plus the one-cycle ILLEGAL / MEM_ERR causes.
    always_comb begin
        state_nx = state;
        ill_nx   = 1'b0;
        err_nx   = 1'b0;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH:  if (accept) state_nx = S_DECODE;
            S_DECODE: begin
                if (!ir_op[3] || ir_op == OP_LDI || ir_op == OP_MOV) begin
                    state_nx = S_EXEC;
                end else if (ir_op == OP_LD || ir_op == OP_ST) begin
                    state_nx = S_MEM;
                end else if (ir_op == OP_HALT) begin
                    state_nx = S_HALT;
                end else begin
                    state_nx = S_FETCH;
                    ill_nx   = 1'b1;
                end
            end
            S_EXEC:   state_nx = S_WB;
            S_MEM: begin
                // ACK wins over a timeout landing in the same cycle.
                if (MEM_ACK) begin
                    state_nx = (ir_op == OP_LD) ? S_WB : S_FETCH;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = S_FETCH;
                    err_nx   = 1'b1;
                end
            end
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register and control outputs, all registered from next state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            INSTR_READY <= 1'b0;
            BUSY        <= 1'b0;
            MEM_REQ     <= 1'b0;
            MEM_WE      <= 1'b0;
            REG_WR      <= 1'b0;
            HALTED      <= 1'b0;
            ILLEGAL     <= 1'b0;
            MEM_ERR     <= 1'b0;
        end else begin
            state       <= state_nx;
            INSTR_READY <= (state_nx == S_FETCH);
            BUSY        <= (state_nx == S_DECODE) || (state_nx == S_EXEC) ||
                           (state_nx == S_MEM)    || (state_nx == S_WB);
            MEM_REQ     <= (state_nx == S_MEM);
            MEM_WE      <= (state_nx == S_MEM) && (ir_op == OP_ST);
            REG_WR      <= (state_nx == S_WB);
            HALTED      <= (state_nx == S_HALT);
            ILLEGAL     <= ill_nx;
            MEM_ERR     <= err_nx;
        end
    end

    // MEM cycle counter; restarts on every MEM entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= 8'd0;
        end else if (state == S_MEM && state_nx == S_MEM) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= 8'd0;
        end
    end

    // IR and datapath fields load on the accept edge (DECODE entry) and then
    // hold until the next accepted instruction.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir_op  <= 4'd0;
            Rz     <= 4'd0;
            Rx     <= 4'd0;
            Ry     <= 4'd0;
            ALU_OP <= 3'd0;
            WB_SEL <= 2'b00;
            IMM    <= 16'd0;
        end else if (state == S_FETCH && accept) begin
            ir_op  <= INSTR[15:12];
            Rz     <= INSTR[11:8];
            Rx     <= INSTR[7:4];
            Ry     <= INSTR[3:0];
            ALU_OP <= INSTR[15] ? 3'd0 : INSTR[14:12];
            WB_SEL <= wb_sel_dec;
            IMM    <= {8'd0, INSTR[7:0]};
        end
    end

endmodule
